// File: rtl/instr_mem_dp_if.sv
// -----------------------------------------------------------------------------
// instr_mem_dp_if
// Bundles the fetch (read), load (write) and clear-control signals of the
// dual-port instruction memory. clk and rst are not part of the bundle.
//
// Parameters
//   DATA_WIDTH : word width in bits (multiple of 8)
//   ADDR_WIDTH : word-address width
//   FETCH_AW   : fetch address width (ADDR_WIDTH, plus byte-offset bits when
//                the memory is byte addressed)
//
// Signals (direction seen from the memory, i.e. the slave modport)
//   fetch_req      in   fetch request
//   fetch_addr     in   fetch address (byte or word address)
//   fetch_ready    out  fetch accepted this cycle when high
//   fetch_valid    out  one-cycle pulse, fetch_data/fetch_misalign valid
//   fetch_data     out  fetched word
//   fetch_misalign out  accepted address had nonzero byte-offset bits
//   load_we        in   write request
//   load_addr      in   word address of the write
//   load_data      in   write data
//   load_be        in   byte enables, bit i covers bits [8i+7:8i]
//   load_ready     out  write accepted this cycle when high
//   clear_req      in   start a full clear sweep
//   busy           out  clear sweep in progress
//
// Handshake rules (both ports):
//   A transfer happens on the rising edge at the end of any cycle in which
//   the request (fetch_req / load_we) and the matching ready are both high.
//   Ready does not depend on the request. A request seen while ready is low
//   is simply dropped; the master must hold or re-issue it itself. A fetch
//   transferred in cycle N is answered by fetch_valid high in cycle N+1 only;
//   there is no back-pressure on the response.
// -----------------------------------------------------------------------------
interface instr_mem_dp_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int FETCH_AW   = 12
);
  localparam int NBYTES = DATA_WIDTH / 8;

  // fetch port
  logic                  fetch_req;
  logic [FETCH_AW-1:0]   fetch_addr;
  logic                  fetch_ready;
  logic                  fetch_valid;
  logic [DATA_WIDTH-1:0] fetch_data;
  logic                  fetch_misalign;

  // load port
  logic                  load_we;
  logic [ADDR_WIDTH-1:0] load_addr;
  logic [DATA_WIDTH-1:0] load_data;
  logic [NBYTES-1:0]     load_be;
  logic                  load_ready;

  // clear control / status
  logic                  clear_req;
  logic                  busy;

  // The requester (datapath or bench) side.
  modport master (
    output fetch_req,
    output fetch_addr,
    input  fetch_ready,
    input  fetch_valid,
    input  fetch_data,
    input  fetch_misalign,
    output load_we,
    output load_addr,
    output load_data,
    output load_be,
    input  load_ready,
    output clear_req,
    input  busy
  );

  // The memory side.
  modport slave (
    input  fetch_req,
    input  fetch_addr,
    output fetch_ready,
    output fetch_valid,
    output fetch_data,
    output fetch_misalign,
    input  load_we,
    input  load_addr,
    input  load_data,
    input  load_be,
    output load_ready,
    input  clear_req,
    output busy
  );

endinterface

// File: rtl/instr_mem_dp.sv
// -----------------------------------------------------------------------------
// instr_mem_dp
// Dual-port instruction memory for the MIPS datapath.
//   * Fetch port: registered read, one-cycle latency, request/valid handshake.
//     With BYTE_ADDR=1 the fetch address is a byte address; the low offset
//     bits select nothing and only raise fetch_misalign when nonzero.
//   * Load port: byte-enabled word writes.
//   * A clear sweep writes zero to every word, one word per cycle, after reset
//     (CLEAR_ON_RESET=1) or when clear_req is seen in RUN. Both ports are
//     stalled (ready low) for the whole sweep.
//
// Parameters
//   DATA_WIDTH     : word width, multiple of 8
//   ADDR_WIDTH     : word-address width, DEPTH = 2**ADDR_WIDTH
//   BYTE_ADDR      : 1 = fetch_addr is a byte address, 0 = word address
//   CLEAR_ON_RESET : 1 = sweep after reset, 0 = come out of reset in RUN
//
// Ports
//   clk           clock, rising edge
//   rst           asynchronous active-high reset
//   bus           instr_mem_dp_if slave modport (fetch/load/clear signals)
//   dbg_state_o   1 = RUN, 0 = CLEAR
//   dbg_clr_cnt_o current clear-sweep address
// -----------------------------------------------------------------------------
module instr_mem_dp #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 10,
  parameter bit BYTE_ADDR      = 1'b1,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  instr_mem_dp_if.slave         bus,
  output logic                  dbg_state_o,
  output logic [ADDR_WIDTH-1:0] dbg_clr_cnt_o
);

  // ---------------------------------------------------------------------------
  // Derived sizes
  // ---------------------------------------------------------------------------
  localparam int DEPTH    = 1 << ADDR_WIDTH;
  localparam int NBYTES   = DATA_WIDTH / 8;
  localparam int OFF      = BYTE_ADDR ? $clog2(NBYTES) : 0;
  localparam int FETCH_AW = ADDR_WIDTH + OFF;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  typedef enum logic {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  localparam state_t RESET_STATE = CLEAR_ON_RESET ? S_CLEAR : S_RUN;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;

  // Registered fetch response.
  logic                  fetch_valid_q;
  logic [DATA_WIDTH-1:0] fetch_data_q;
  logic                  fetch_mis_q;

  // Storage. Deliberately has no reset; only the clear sweep zeroes it.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // ---------------------------------------------------------------------------
  // Combinational decode
  // ---------------------------------------------------------------------------
  logic                  run_w;
  logic                  fetch_acc_w;
  logic                  load_acc_w;
  logic                  clr_we_w;
  logic [ADDR_WIDTH-1:0] fetch_idx_w;
  logic                  fetch_mis_w;

  // Word index is the upper part of the fetch address; the offset bits (if
  // any) never steer the read.
  assign fetch_idx_w = bus.fetch_addr[FETCH_AW-1:OFF];

  generate
    if (OFF > 0) begin : g_byte_addr
      assign fetch_mis_w = |bus.fetch_addr[OFF-1:0];
    end else begin : g_word_addr
      assign fetch_mis_w = 1'b0;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // FSM: next state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    run_w     = 1'b0;
    clr_we_w  = 1'b0;

    case (state_q)
      S_CLEAR: begin
        // One zero write per cycle; the counter wraps to 0 naturally after
        // the last word, so the next sweep starts from a clean count.
        clr_we_w  = 1'b1;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (&clr_cnt_q) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        run_w = 1'b1;
        // A load or fetch in this same cycle is still carried out; the
        // sweep only starts on the next cycle.
        if (bus.clear_req) begin
          state_d   = S_CLEAR;
          clr_cnt_d = '0;
        end
      end
      default: begin
        state_d   = RESET_STATE;
        clr_cnt_d = '0;
      end
    endcase
  end

  assign fetch_acc_w = bus.fetch_req & run_w;
  assign load_acc_w  = bus.load_we & run_w;

  // ---------------------------------------------------------------------------
  // Control and fetch-response registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RESET_STATE;
      clr_cnt_q     <= '0;
      fetch_valid_q <= 1'b0;
      fetch_data_q  <= '0;
      fetch_mis_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      clr_cnt_q     <= clr_cnt_d;
      fetch_valid_q <= fetch_acc_w;
      // Data and misalign hold their last value when nothing is accepted.
      // The read samples the array before this edge's write lands, which
      // gives read-before-write for a same-cycle fetch and load.
      if (fetch_acc_w) begin
        fetch_data_q <= mem_q[fetch_idx_w];
        fetch_mis_q  <= fetch_mis_w;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Array write port: clear sweep or byte-enabled load, never both (they are
  // active in different states).
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (clr_we_w) begin
      mem_q[clr_cnt_q] <= '0;
    end else if (load_acc_w) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (bus.load_be[i]) begin
          mem_q[bus.load_addr][8*i +: 8] <= bus.load_data[8*i +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.fetch_ready    = run_w;
  assign bus.load_ready     = run_w;
  assign bus.busy           = (state_q == S_CLEAR);
  assign bus.fetch_valid    = fetch_valid_q;
  assign bus.fetch_data     = fetch_data_q;
  assign bus.fetch_misalign = fetch_mis_q;

  assign dbg_state_o   = (state_q == S_RUN);
  assign dbg_clr_cnt_o = clr_cnt_q;

endmodule

// File: doc/instr_mem_dp.md
Name: instr_mem_dp

Overview:
- Parametrised dual-port instruction memory for the MIPS datapath.
- Separate unidirectional fetch (read) and load (write) ports; no shared bidirectional data bus.
- Fetch port: one-cycle registered read with request/valid handshake. Optional byte addressing with misalignment flag.
- Load port: byte-enabled writes. Built-in clear FSM zeroes the whole array after reset or on request.

Parameters:
- DATA_WIDTH, 32: word width in bits. Must be a multiple of 8.
- ADDR_WIDTH, 10: word-address width. DEPTH = 2**ADDR_WIDTH words.
- BYTE_ADDR, 1: 1 = fetch_addr is a byte address; 0 = fetch_addr is a word address.
- CLEAR_ON_RESET, 1: 1 = run the clear sweep after reset; 0 = enter RUN directly.
- Derived: NBYTES = DATA_WIDTH/8; OFF = BYTE_ADDR ? log2(NBYTES) : 0.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- fetch_req  in  1  fetch request.
- fetch_addr  in  ADDR_WIDTH+OFF  fetch address. Word index = fetch_addr[ADDR_WIDTH+OFF-1:OFF].
- fetch_ready  out  1  fetch accepted this cycle when high.
- fetch_valid  out  1  fetch_data valid (one-cycle pulse).
- fetch_data  out  DATA_WIDTH  fetched word.
- fetch_misalign  out  1  accompanies fetch_valid; low offset bits of the accepted address were nonzero.
- load_we  in  1  write request.
- load_addr  in  ADDR_WIDTH  word address of write.
- load_data  in  DATA_WIDTH  write data.
- load_be  in  NBYTES  byte enables; bit i covers bits [8i+7:8i].
- load_ready  out  1  write accepted this cycle when high.
- clear_req  in  1  start a full clear sweep (sampled in RUN only).
- busy  out  1  clear sweep in progress.

Behaviour:
- States: CLEAR, RUN. Counter clr_cnt is ADDR_WIDTH bits.
- rst high:
  - state = CLEAR if CLEAR_ON_RESET, else RUN.
  - clr_cnt = 0; fetch_valid = 0; fetch_data = 0; fetch_misalign = 0.
  - busy = CLEAR_ON_RESET.
  - Array contents are not reset.
- CLEAR:
  - Each cycle writes all-zero to mem[clr_cnt], then increments clr_cnt.
  - When clr_cnt == DEPTH-1 the write occurs, clr_cnt wraps to 0 and state goes to RUN.
  - Sweep takes exactly DEPTH cycles.
  - busy = 1; fetch_ready = 0; load_ready = 0.
  - fetch_req, load_we and clear_req are ignored.
- RUN:
  - busy = 0; fetch_ready = 1; load_ready = 1.
  - clear_req = 1 enters CLEAR next cycle with clr_cnt = 0.
  - A load or fetch in the same cycle as clear_req is still performed.
- Fetch:
  - Accepted when fetch_req & fetch_ready in cycle N.
  - Cycle N+1: fetch_valid = 1, fetch_data = mem[word index], fetch_misalign = |fetch_addr[OFF-1:0] (0 when OFF = 0).
  - No accept in cycle N: fetch_valid = 0 in N+1 and fetch_data holds its last value.
  - Back-to-back accepts give back-to-back valids.
- Load:
  - Accepted when load_we & load_ready.
  - At the clock edge, byte i of mem[load_addr] takes load_data byte i where load_be[i] = 1; other bytes are unchanged.
  - load_be = 0 is a legal no-op.
- Same-cycle fetch and load to the same word: read-before-write. The fetch returns the pre-write word; the following fetch returns the updated word.
- rst asserted mid-sweep: sweep restarts from address 0 after rst deasserts. Words already cleared remain 0.
- rst asserted while a fetch is outstanding: the pending fetch_valid is dropped (0).
- Address arithmetic is modulo DEPTH. clr_cnt wraps; no out-of-range access exists.

Test Plan:
1. DEPTH=1024, CLEAR_ON_RESET=1. Pulse rst, then fetch word 5 as soon as fetch_ready rises. Required: busy = 1 for exactly 1024 cycles, fetch_ready = 0 throughout, then fetch_data = 0x00000000 one cycle after accept.
2. Load word 3 = 0xDEADBEEF with be = 4'b1111, then load 0x00000011 with be = 4'b0001, then fetch byte address 12. Required: fetch_data = 0xDEADBE11, fetch_misalign = 0, latency exactly 1 cycle.
3. Same cycle: load word 7 = 0xCAFEF00D and fetch word 7 (previously 0x12345678). Required: first fetch returns 0x12345678; next fetch returns 0xCAFEF00D.
4. BYTE_ADDR=1: fetch byte address 13. Required: returns word 3 with fetch_misalign = 1. Fetch address 0xFFC returns word 1023.
5. In RUN, pulse clear_req together with a load. Required: busy = 1 next cycle, loads blocked (load_ready = 0) for 1024 cycles, afterwards every word reads 0. Assert rst at sweep cycle 500: sweep restarts and again lasts 1024 cycles.
6. Issue 8 consecutive fetch_req cycles to words 0..7 after loading value = index. Required: 8 consecutive fetch_valid pulses with data 0..7 in order. With no request, fetch_valid = 0 and fetch_data is held.
